// File: rtl/tft_draw_arbiter.sv
// rtl/tft_draw_arbiter.sv - round-robin arbiter sharing one TFT rectangle-fill engine among NREQ requesters
// The owner's rectangle is latched at grant; colour and pixel strobes are routed live.
module tft_draw_arbiter #(
  parameter int          NREQ    = 4,
  parameter logic [23:0] TIMEOUT = 24'd2000000
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic [NREQ-1:0]      req,
  input  logic [64*NREQ-1:0]   rect,
  input  logic [16*NREQ-1:0]   color,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      start,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      cnext_out,
  output logic                 tft_draw,
  output logic [15:0]          tft_xstart,
  output logic [15:0]          tft_xend,
  output logic [15:0]          tft_ystart,
  output logic [15:0]          tft_yend,
  output logic [15:0]          tft_color,
  input  logic                 tft_cnext,
  input  logic                 tft_done,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, ptr, winner;
  logic            found;
  logic [OW:0]     cand;
  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] done_r;
  logic [23:0]     wait_cnt;
  logic            finish, abort;
  logic [63:0]     rect_sel;

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (OW+1)'(i);
      if (cand >= (OW+1)'(NREQ))
        cand = cand - (OW+1)'(NREQ);
      if (!found && req[cand[OW-1:0]]) begin
        found  = 1'b1;
        winner = cand[OW-1:0];
      end
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  assign rect_sel = rect[64*int'(winner) +: 64];

  // A tft_done coinciding with the last allowed cycle counts as a normal finish.
  assign finish = (state == WAIT) && tft_done;
  assign abort  = (state == WAIT) && !tft_done && (wait_cnt == TIMEOUT - 24'd1);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (finish || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      owner       <= '0;
      ptr         <= '0;
      done_r      <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      tft_xstart  <= '0;
      tft_xend    <= '0;
      tft_ystart  <= '0;
      tft_yend    <= '0;
    end else begin
      done_r <= '0;
      if (state == IDLE && found) begin
        owner      <= winner;
        tft_xstart <= rect_sel[63:48];
        tft_xend   <= rect_sel[47:32];
        tft_ystart <= rect_sel[31:16];
        tft_yend   <= rect_sel[15:0];
      end
      if (state == WAIT && state_nxt == WAIT)
        wait_cnt <= wait_cnt + 24'd1;
      else
        wait_cnt <= '0;
      if (finish || abort) begin
        done_r <= owner_oh;
        ptr    <= (owner == OW'(NREQ-1)) ? '0 : owner + OW'(1);
      end
      if (abort)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign gnt       = busy ? owner_oh : '0;
  assign tft_draw  = (state == ISSUE);
  assign start     = tft_draw ? owner_oh : '0;
  assign done      = done_r;
  assign cnext_out = ((state == WAIT) && tft_cnext) ? owner_oh : '0;
  assign tft_color = busy ? color[16*int'(owner) +: 16] : 16'h0000;

endmodule

// File: tb/tb_tft_draw_arbiter.sv
// tb/tb_tft_draw_arbiter.sv - scoreboard bench for tft_draw_arbiter
module tb_tft_draw_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0, arstn = 1'b0;
  logic [N-1:0]    req;
  logic [64*N-1:0] rect;
  logic [16*N-1:0] color;
  logic [N-1:0]    gnt, start, done, cnext_out;
  logic            tft_draw, tft_cnext, tft_done, busy, timeout_err, err_clr;
  logic [15:0]     tft_xstart, tft_xend, tft_ystart, tft_yend, tft_color;
  logic            man_done, auto_pulse;

  logic [N-1:0]    to_req, to_gnt, to_start, to_done_o, to_cnext_out;
  logic            to_draw, to_busy, to_err, to_clr, to_tft_done, to_cnext;
  logic [15:0]     to_xs, to_xe, to_ys, to_ye, to_color;

  assign tft_done = man_done | auto_pulse;

  tft_draw_arbiter #(.NREQ(N)) dut (
    .clk(clk), .arstn(arstn), .req(req), .rect(rect), .color(color),
    .gnt(gnt), .start(start), .done(done), .cnext_out(cnext_out),
    .tft_draw(tft_draw), .tft_xstart(tft_xstart), .tft_xend(tft_xend),
    .tft_ystart(tft_ystart), .tft_yend(tft_yend), .tft_color(tft_color),
    .tft_cnext(tft_cnext), .tft_done(tft_done), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  tft_draw_arbiter #(.NREQ(N), .TIMEOUT(24'd16)) dut_to (
    .clk(clk), .arstn(arstn), .req(to_req), .rect(rect), .color(color),
    .gnt(to_gnt), .start(to_start), .done(to_done_o), .cnext_out(to_cnext_out),
    .tft_draw(to_draw), .tft_xstart(to_xs), .tft_xend(to_xe),
    .tft_ystart(to_ys), .tft_yend(to_ye), .tft_color(to_color),
    .tft_cnext(to_cnext), .tft_done(to_tft_done), .busy(to_busy),
    .timeout_err(to_err), .err_clr(to_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [63:0] r;
    logic [15:0] c;
  } txn_t;

  txn_t exp_q[$];
  int   done_q[$];
  txn_t mt;
  int   tests = 0, fails = 0;
  int   draw_cnt = 0, done_cnt = 0, cnext_cnt = 0;
  logic prev_busy = 1'b0;
  logic auto_done = 1'b1;
  int   done_delay = 5;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_rect(input int i);
    return {16'(i*100 + 1), 16'(i*100 + 20), 16'(i*100 + 40), 16'(i*100 + 60)};
  endfunction

  task automatic push_exp(input int o);
    txn_t t;
    t.owner = o;
    t.r     = rect[64*o +: 64];
    t.c     = color[16*o +: 16];
    exp_q.push_back(t);
  endtask

  task automatic wait_draws(input int n);
    for (int i = 0; i < 500 && draw_cnt < n; i++) @(negedge clk);
    if (draw_cnt < n) check("wait_draws", 64'(draw_cnt), 64'(n));
  endtask

  task automatic wait_dones(input int n);
    for (int i = 0; i < 500 && done_cnt < n; i++) @(negedge clk);
    if (done_cnt < n) check("wait_dones", 64'(done_cnt), 64'(n));
  endtask

  // Scoreboard monitor: grants pop expected transactions, done pulses pop expected owners.
  always @(negedge clk) begin
    #2;
    if (arstn) begin
      check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      if (start != 0) check("start_only_in_issue", 64'(tft_draw), 64'd1);
      if (tft_draw) begin
        draw_cnt++;
        if (exp_q.size() == 0) begin
          check("draw_unexpected", 64'(gnt), 64'd0);
        end else begin
          mt = exp_q.pop_front();
          check("grant_owner", 64'(gnt), 64'(1 << mt.owner));
          check("start_owner", 64'(start), 64'(1 << mt.owner));
          check("rect_latched", {tft_xstart, tft_xend, tft_ystart, tft_yend}, mt.r);
          check("color_routed", 64'(tft_color), 64'(mt.c));
          check("idle_gap", 64'(prev_busy), 64'd0);
          done_q.push_back(mt.owner);
        end
      end
      if (done != 0) begin
        done_cnt++;
        if (done_q.size() == 0) check("done_unexpected", 64'(done), 64'd0);
        else check("done_owner", 64'(done), 64'(1 << done_q.pop_front()));
      end
      if (cnext_out != 0) begin
        check("cnext_route", 64'(cnext_out), 64'(gnt));
        cnext_cnt++;
      end
    end
    prev_busy = busy;
  end

  // Engine model: answers each draw with tft_done after done_delay cycles.
  initial begin
    auto_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (arstn && auto_done && tft_draw) begin
        repeat (done_delay) @(negedge clk);
        auto_pulse = 1'b1;
        @(negedge clk);
        auto_pulse = 1'b0;
      end
    end
  end

  initial begin
    int n;
    req = '0; man_done = 1'b0; tft_cnext = 1'b0; err_clr = 1'b0;
    to_req = '0; to_clr = 1'b0; to_tft_done = 1'b0; to_cnext = 1'b0;
    for (int i = 0; i < N; i++) begin
      rect[64*i +: 64]  = mk_rect(i);
      color[16*i +: 16] = 16'(16'h1111 * (i + 1));
    end
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_draw", 64'(tft_draw), 64'd0);
    check("rst_err", 64'(timeout_err), 64'd0);
    check("rst_rect", {tft_xstart, tft_xend, tft_ystart, tft_yend}, 64'd0);
    check("rst_color", 64'(tft_color), 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);

    // All four requesting: order 0,1,2,3,0
    for (int i = 0; i < N; i++) push_exp(i);
    push_exp(0);
    req = 4'b1111;
    wait_draws(5);
    req = '0;
    wait_dones(5);
    repeat (3) @(negedge clk);

    // Single requester 2, rectangle held after grant
    rect[128 +: 64] = {16'd10, 16'd49, 16'd110, 16'd149};
    push_exp(2);
    req = 4'b0100;
    wait_draws(6);
    req = '0;
    rect[128 +: 64] = '1;
    @(negedge clk);
    #2;
    check("rect_hold", {tft_xstart, tft_xend, tft_ystart, tft_yend},
          {16'd10, 16'd49, 16'd110, 16'd149});
    wait_dones(6);
    repeat (2) @(negedge clk);

    // Pixel strobes routed to owner 1
    auto_done = 1'b0;
    color[16 +: 16] = 16'hF800;
    push_exp(1);
    req = 4'b0010;
    wait_draws(7);
    req = '0;
    cnext_cnt = 0;
    repeat (40) begin
      tft_cnext = 1'b1;
      @(negedge clk);
      tft_cnext = 1'b0;
      @(negedge clk);
    end
    #2;
    check("cnext_count", 64'(cnext_cnt), 64'd40);
    check("cnext_color", 64'(tft_color), 64'hF800);
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    wait_dones(7);
    repeat (2) @(negedge clk);

    // tft_done in IDLE and in ISSUE is ignored
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    #2;
    check("idle_done_busy", 64'(busy), 64'd0);
    check("idle_done_count", 64'(done_cnt), 64'd7);
    @(negedge clk);
    push_exp(1);
    req = 4'b0010;
    @(negedge clk);
    #2;
    check("in_issue", 64'(tft_draw), 64'd1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    #2;
    check("issue_done_busy", 64'(busy), 64'd1);
    check("issue_done_count", 64'(done_cnt), 64'd7);
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    wait_dones(8);
    repeat (2) @(negedge clk);

    // Reset in the middle of owner 3's WAIT
    push_exp(3);
    req = 4'b1000;
    wait_draws(9);
    req = '0;
    repeat (4) @(negedge clk);
    #2;
    arstn = 1'b0;
    #1;
    check("mid_rst_gnt", 64'(gnt), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_start", 64'(start), 64'd0);
    check("mid_rst_rect", {tft_xstart, tft_xend, tft_ystart, tft_yend}, 64'd0);
    check("mid_rst_color", 64'(tft_color), 64'd0);
    done_q.delete();
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    auto_done = 1'b1;
    push_exp(0);
    push_exp(3);
    req = 4'b1001;
    wait_draws(11);
    req = '0;
    wait_dones(10);
    repeat (3) @(negedge clk);
    check("queues_empty", 64'(exp_q.size() + done_q.size()), 64'd0);

    // Timeout on the TIMEOUT=16 instance: owner 2 never completes
    to_req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (to_draw) break;
    end
    check("to_draw", 64'(to_start), 64'b0100);
    to_req = '0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      n++;
      if (to_done_o != 0) break;
    end
    check("to_latency", 64'(n), 64'd17);
    check("to_done_owner", 64'(to_done_o), 64'b0100);
    check("to_err_set", 64'(to_err), 64'd1);
    check("to_idle", 64'(to_busy), 64'd0);
    repeat (3) @(negedge clk);
    #2;
    check("to_err_sticky", 64'(to_err), 64'd1);
    to_clr = 1'b1;
    @(negedge clk);
    #2;
    to_clr = 1'b0;
    check("to_err_clr", 64'(to_err), 64'd0);

    // Next requester (3) served; tft_done on the final allowed cycle is a normal finish
    to_req = 4'b1001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (to_draw) break;
    end
    check("to_next_gnt", 64'(to_gnt), 64'b1000);
    to_req = '0;
    repeat (16) @(negedge clk);
    to_tft_done = 1'b1;
    @(negedge clk);
    to_tft_done = 1'b0;
    #2;
    check("to_coinc_done", 64'(to_done_o), 64'b1000);
    check("to_coinc_err", 64'(to_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tft_draw_arbiter.md
TFT_DRAW_ARBITER -- requirements
Module: tft_draw_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of drawing requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 24'd2000000, clk cycles allowed per transaction before abort.
REQ-003 SHALL have ports:
  clk  in  1  clock
  arstn  in  1  reset, asynchronous, active-low
  req  in  NREQ  per-requester draw request, level (requester's update)
  rect  in  64*NREQ  per-requester {xstart,xend,ystart,yend}, 16b each, requester i at bits [64*i+63:64*i]
  color  in  16*NREQ  per-requester pixel colour, requester i at bits [16*i+15:16*i]
  gnt  out  NREQ  one-hot owner of the TFT engine, level
  start  out  NREQ  one-cycle pulse telling owner to begin (requester's draw)
  done  out  NREQ  one-cycle pulse telling owner its rectangle finished
  cnext_out  out  NREQ  next-pixel strobe routed to owner
  tft_draw  out  1  one-cycle start pulse to TFT engine
  tft_xstart, tft_xend, tft_ystart, tft_yend  out  16 each  latched rectangle
  tft_color  out  16  owner's colour
  tft_cnext  in  1  TFT engine pixel-consumed strobe
  tft_done  in  1  TFT engine rectangle complete, one-cycle pulse
  busy  out  1  transaction in progress
  timeout_err  out  1  sticky abort flag
  err_clr  in  1  clears timeout_err

Function
REQ-004 SHALL implement FSM IDLE, ISSUE, WAIT; encoding free.
REQ-005 IDLE: when req != 0, SHALL pick winner round-robin, searching from ptr upward modulo NREQ; on the same edge SHALL register owner, set gnt[owner], latch rect[owner] into tft_x*/tft_y*, go ISSUE.
REQ-006 ISSUE: tft_draw and start[owner] SHALL both be 1 for exactly this one cycle; next state WAIT.
REQ-007 WAIT: on tft_done=1, SHALL go IDLE, clear gnt, pulse done[owner] for one cycle, set ptr = (owner+1) mod NREQ.
REQ-008 Latency: req sampled high at edge k in IDLE -> tft_draw high in cycle k..k+1; back-to-back requests SHALL give one IDLE cycle minimum between transactions.
REQ-009 tft_color SHALL be combinational color[owner] while gnt != 0, else 16'h0000.
REQ-010 cnext_out[owner] SHALL equal tft_cnext while state is WAIT; all other bits 0.
REQ-011 tft_x*/tft_y* SHALL hold the latched values until the next grant; later rect changes ignored.
REQ-012 req deasserted by owner during ISSUE/WAIT SHALL NOT abort; transaction completes normally.
REQ-013 tft_done outside WAIT SHALL be ignored.
REQ-014 Requests arriving during ISSUE/WAIT SHALL wait; none dropped while level held.
REQ-015 WAIT cycle counter SHALL reach TIMEOUT-1 then abort: return IDLE, pulse done[owner], set timeout_err, advance ptr as REQ-007.
REQ-016 tft_done and timeout on same cycle SHALL count as normal completion, timeout_err unchanged.
REQ-017 err_clr SHALL clear timeout_err; set by simultaneous timeout SHALL win over err_clr.
REQ-018 busy SHALL be 1 in ISSUE and WAIT, 0 in IDLE.
REQ-019 gnt SHALL be one-hot or zero at all times.

Reset
REQ-020 arstn low SHALL force, at any point (incl. mid-WAIT): state IDLE, ptr 0, gnt/start/done/cnext_out 0, tft_draw 0, tft_x*/tft_y* 0, busy 0, timeout_err 0, counter 0; no done pulse for the aborted owner.
REQ-021 First arbitration after reset SHALL favour requester 0.

Verification
REQ-022 req=4'b1111 held, tft_done 5 cycles after each tft_draw -> grant order 0,1,2,3,0; one done pulse each; one IDLE cycle between.
REQ-023 req=4'b0100, rect2={10,49,110,149} -> tft_xstart=10, tft_xend=49, tft_ystart=110, tft_yend=149; tft_draw one cycle; start[2] one cycle.
REQ-024 owner 1 in WAIT, tft_cnext toggled 40 times, color[1]=16'hF800 -> cnext_out[1] 40 pulses, other bits 0; tft_color=16'hF800.
REQ-025 TIMEOUT=16, tft_done never -> abort after 16 WAIT cycles, done[owner] pulse, timeout_err=1 until err_clr; next requester then served.
REQ-026 arstn low mid-WAIT of owner 3 -> all outputs 0 immediately, no done; after release req=4'b1001 grants 0 first.
REQ-027 tft_done pulsed in IDLE and ISSUE -> ignored, no done pulse, no state change.
